// File: rtl/ysyx_22040237_cpu_ctrl.sv
// Multi-cycle sequencer for the ysyx_22040237 RV64 core: walks each instruction through fetch,
// execute, optional load/store and writeback, raises the commit strobes and keeps mcycle/minstret.
module ysyx_22040237_cpu_ctrl #(
    parameter int unsigned CNT_W   = 64,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    output logic             if_req_valid,
    input  logic             if_req_ready,
    input  logic             if_rsp_valid,
    input  logic             if_rsp_err,
    output logic             inst_latch_en,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             rd_w_en,
    input  logic             inst_ebreak,
    input  logic             invalid_inst,
    output logic             lsu_req_valid,
    input  logic             lsu_req_ready,
    input  logic             lsu_rsp_valid,
    input  logic             lsu_rsp_err,
    output logic             pc_we,
    output logic             rf_we,
    output logic             halted,
    output logic [1:0]       halt_code,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    typedef enum logic [2:0] {
        S_BOOT     = 3'd0,
        S_IF_REQ   = 3'd1,
        S_IF_WAIT  = 3'd2,
        S_EXEC     = 3'd3,
        S_MEM_REQ  = 3'd4,
        S_MEM_WAIT = 3'd5,
        S_WB       = 3'd6,
        S_HALT     = 3'd7
    } state_e;

    localparam logic [1:0] HC_EBREAK  = 2'b00;
    localparam logic [1:0] HC_ILLEGAL = 2'b01;
    localparam logic [1:0] HC_IFU     = 2'b10;
    localparam logic [1:0] HC_LSU     = 2'b11;

    // TO_LAST is meaningless when TIMEOUT is 0; TO_EN masks it off in that case.
    localparam bit               TO_EN   = (TIMEOUT != 32'd0);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 32'd1);
    localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);

    function automatic logic is_wait_state(input state_e s);
        return (s == S_IF_REQ) || (s == S_IF_WAIT) || (s == S_MEM_REQ) || (s == S_MEM_WAIT);
    endfunction

    state_e           state_q;
    state_e           state_d;
    logic             halted_q;
    logic             halted_d;
    logic [1:0]       code_q;
    logic [1:0]       code_d;
    logic [TO_W-1:0]  to_q;
    logic [TO_W-1:0]  to_d;
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] cycle_d;
    logic [CNT_W-1:0] instret_q;
    logic [CNT_W-1:0] instret_d;
    logic             waiting_s;
    logic             to_hit_s;

    // Next state, halt cause, timeout and counter updates
    always_comb begin
        state_d   = state_q;
        halted_d  = halted_q;
        code_d    = code_q;
        waiting_s = is_wait_state(state_q);
        to_hit_s  = TO_EN && waiting_s && (to_q == TO_LAST);

        case (state_q)
            S_BOOT: begin
                state_d = S_IF_REQ;
            end
            S_IF_REQ: begin
                if (if_req_ready) begin
                    state_d = S_IF_WAIT;
                end else if (to_hit_s) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                    code_d   = HC_IFU;
                end else begin
                    state_d = S_IF_REQ;
                end
            end
            S_IF_WAIT: begin
                // A completed handshake wins over a timeout expiring in the same cycle.
                if (if_rsp_valid && !if_rsp_err) begin
                    state_d = S_EXEC;
                end else if (if_rsp_valid || to_hit_s) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                    code_d   = HC_IFU;
                end else begin
                    state_d = S_IF_WAIT;
                end
            end
            S_EXEC: begin
                if (invalid_inst) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                    code_d   = HC_ILLEGAL;
                end else if (inst_ebreak) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                    code_d   = HC_EBREAK;
                end else if (is_load || is_store) begin
                    state_d = S_MEM_REQ;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM_REQ: begin
                if (lsu_req_ready) begin
                    state_d = S_MEM_WAIT;
                end else if (to_hit_s) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                    code_d   = HC_LSU;
                end else begin
                    state_d = S_MEM_REQ;
                end
            end
            S_MEM_WAIT: begin
                if (lsu_rsp_valid && !lsu_rsp_err) begin
                    state_d = S_WB;
                end else if (lsu_rsp_valid || to_hit_s) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                    code_d   = HC_LSU;
                end else begin
                    state_d = S_MEM_WAIT;
                end
            end
            S_WB: begin
                state_d = S_IF_REQ;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase

        if ((state_d != state_q) || !waiting_s) begin
            to_d = {TO_W{1'b0}};
        end else begin
            to_d = to_q + TO_ONE;
        end

        if (state_q != S_HALT) begin
            cycle_d = cycle_q + CNT_ONE;
        end else begin
            cycle_d = cycle_q;
        end

        if (state_q == S_WB) begin
            instret_d = instret_q + CNT_ONE;
        end else begin
            instret_d = instret_q;
        end
    end

    // Sequencer state, sticky halt status and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_BOOT;
            halted_q  <= 1'b0;
            code_q    <= 2'b00;
            to_q      <= {TO_W{1'b0}};
            cycle_q   <= {CNT_W{1'b0}};
            instret_q <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            halted_q  <= halted_d;
            code_q    <= code_d;
            to_q      <= to_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    // Request strobes are pure state decodes, so only one interface can ever be requesting.
    assign if_req_valid  = (state_q == S_IF_REQ);
    assign lsu_req_valid = (state_q == S_MEM_REQ);
    assign inst_latch_en = (state_q == S_IF_WAIT) && if_rsp_valid && !if_rsp_err;
    assign pc_we         = (state_q == S_WB);
    assign rf_we         = (state_q == S_WB) && rd_w_en;
    assign halted        = halted_q;
    assign halt_code     = code_q;
    assign cycle_cnt     = cycle_q;
    assign instret_cnt   = instret_q;

endmodule

// File: tb/tb_ysyx_22040237_cpu_ctrl.sv
// Randomised bench for ysyx_22040237_cpu_ctrl: per-cycle expectations are built from instruction-level
// phase rules (handshake delays, decode priority, timeout limit) and compared every cycle.
module tb_ysyx_22040237_cpu_ctrl;
    localparam int TO     = 4;
    localparam int K_ALU  = 0;
    localparam int K_LD   = 1;
    localparam int K_ST   = 2;
    localparam int K_EB   = 3;
    localparam int K_INV  = 4;
    localparam int K_BOTH = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_err, inst_latch_en;
    logic        is_load, is_store, rd_w_en, inst_ebreak, invalid_inst;
    logic        lsu_req_valid, lsu_req_ready, lsu_rsp_valid, lsu_rsp_err;
    logic        pc_we, rf_we, halted;
    logic [1:0]  halt_code;
    logic [63:0] cycle_cnt, instret_cnt;

    always #5 clk = ~clk;

    ysyx_22040237_cpu_ctrl #(.CNT_W(64), .TIMEOUT(TO), .TO_W(8)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid), .if_rsp_err(if_rsp_err), .inst_latch_en(inst_latch_en),
        .is_load(is_load), .is_store(is_store), .rd_w_en(rd_w_en),
        .inst_ebreak(inst_ebreak), .invalid_inst(invalid_inst),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_err(lsu_rsp_err),
        .pc_we(pc_we), .rf_we(rf_we), .halted(halted), .halt_code(halt_code),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    // One cycle of stimulus plus the strobes expected in that cycle.
    typedef struct packed {
        logic ifrdy, ifrv, iferr, ld, st, rd, eb, inv, lrdy, lrv, lerr;
        logic e_ifv, e_lsv, e_latch, e_pc, e_rf;
        logic wb, halt_after;
        logic [1:0] code;
    } cyc_t;

    cyc_t        plan[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] exp_cyc, exp_ret, pc_mask;
    logic        exp_halt;
    logic [1:0]  exp_code;
    int          cyc_idx, pc_n, rf_n, ifv_n, lsv_n;
    bit          force_stray = 1'b0;
    bit          plan_halted;

    function automatic cyc_t rnd_cyc();
        cyc_t c;
        logic [10:0] r;
        r = 11'($urandom);
        c = '0;
        {c.ifrdy, c.ifrv, c.iferr, c.ld, c.st, c.rd, c.eb, c.inv, c.lrdy, c.lrv, c.lerr} = r;
        if (force_stray) c.lrv = 1'b1;
        return c;
    endfunction

    task automatic drive(input cyc_t c);
        if_req_ready  = c.ifrdy;  if_rsp_valid  = c.ifrv;  if_rsp_err  = c.iferr;
        is_load       = c.ld;     is_store      = c.st;    rd_w_en     = c.rd;
        inst_ebreak   = c.eb;     invalid_inst  = c.inv;
        lsu_req_ready = c.lrdy;   lsu_rsp_valid = c.lrv;   lsu_rsp_err = c.lerr;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            drive(rnd_cyc());
            @(negedge clk);
        end
        rst = 1'b0;
        exp_cyc = 64'd0; exp_ret = 64'd0; exp_halt = 1'b0; exp_code = 2'b00;
        cyc_idx = 0; pc_n = 0; rf_n = 0; ifv_n = 0; lsv_n = 0; pc_mask = 64'd0;
        plan_halted = 1'b0;
        plan.delete();
        plan.push_back(rnd_cyc());
    endtask

    // Request phase (rdy_dly idle cycles) then response phase (rsp_dly idle cycles); either may time out.
    task automatic plan_hs(input bit mem, input int rdy_dly, input int rsp_dly, input bit err, output bit stop);
        cyc_t c;
        logic [1:0] hc;
        hc = mem ? 2'b11 : 2'b10;
        stop = 1'b0;
        for (int i = 0; i <= rdy_dly && i < TO; i++) begin
            c = rnd_cyc();
            if (mem) begin c.e_lsv = 1'b1; c.lrdy = (i == rdy_dly); end
            else begin c.e_ifv = 1'b1; c.ifrdy = (i == rdy_dly); end
            if (i == TO - 1 && rdy_dly >= TO) begin c.halt_after = 1'b1; c.code = hc; stop = 1'b1; end
            plan.push_back(c);
        end
        if (stop) return;
        for (int i = 0; i <= rsp_dly && i < TO; i++) begin
            c = rnd_cyc();
            if (mem) begin
                c.lrv = (i == rsp_dly);
                if (i == rsp_dly) c.lerr = err;
            end else begin
                c.ifrv = (i == rsp_dly);
                if (i == rsp_dly) c.iferr = err;
                c.e_latch = (i == rsp_dly) && !err;
            end
            if ((i == rsp_dly && err) || (i == TO - 1 && rsp_dly >= TO)) begin
                c.halt_after = 1'b1; c.code = hc; stop = 1'b1;
            end
            plan.push_back(c);
        end
    endtask

    task automatic plan_insn(input int kind, input bit rd, input int ifr, input int ifp, input bit ife,
                             input int mr, input int mp, input bit me);
        cyc_t c;
        bit stop;
        plan_hs(1'b0, ifr, ifp, ife, stop);
        if (stop) begin plan_halted = 1'b1; return; end
        c = rnd_cyc();
        c.ld  = (kind == K_LD);
        c.st  = (kind == K_ST);
        c.eb  = (kind == K_EB) || (kind == K_BOTH);
        c.inv = (kind == K_INV) || (kind == K_BOTH);
        c.rd  = rd;
        if (c.inv) begin c.halt_after = 1'b1; c.code = 2'b01; end
        else if (c.eb) begin c.halt_after = 1'b1; c.code = 2'b00; end
        plan.push_back(c);
        if (c.halt_after) begin plan_halted = 1'b1; return; end
        if (kind == K_LD || kind == K_ST) begin
            plan_hs(1'b1, mr, mp, me, stop);
            if (stop) begin plan_halted = 1'b1; return; end
        end
        c = rnd_cyc();
        c.rd = rd; c.e_pc = 1'b1; c.e_rf = rd; c.wb = 1'b1;
        plan.push_back(c);
    endtask

    task automatic plan_idle(input int n);
        for (int i = 0; i < n; i++) plan.push_back(rnd_cyc());
    endtask

    // Executes the plan; every cycle compares strobes/status and both counters.
    task automatic run_plan();
        cyc_t c;
        logic [7:0] got, exp;
        while (plan.size() > 0) begin
            c = plan.pop_front();
            drive(c);
            #1;
            got = {if_req_valid, lsu_req_valid, inst_latch_en, pc_we, rf_we, halted, halt_code};
            exp = {c.e_ifv, c.e_lsv, c.e_latch, c.e_pc, c.e_rf, exp_halt, exp_code};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL strobes cyc=%0d got(ifv,lsv,latch,pc,rf,halt,code)=%b expected=%b", cyc_idx, got, exp);
            end
            vectors++;
            if (cycle_cnt !== exp_cyc || instret_cnt !== exp_ret) begin
                miscompares++;
                $display("FAIL counters cyc=%0d got cycle=%0d instret=%0d expected cycle=%0d instret=%0d",
                         cyc_idx, cycle_cnt, instret_cnt, exp_cyc, exp_ret);
            end
            if (pc_we) begin
                pc_n++;
                if (cyc_idx < 64) pc_mask[cyc_idx[5:0]] = 1'b1;
            end
            if (rf_we) rf_n++;
            if (if_req_valid) ifv_n++;
            if (lsu_req_valid) lsv_n++;
            if (!exp_halt) exp_cyc = exp_cyc + 64'd1;
            if (c.wb) exp_ret = exp_ret + 64'd1;
            if (c.halt_after) begin exp_halt = 1'b1; exp_code = c.code; end
            cyc_idx++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        do_reset(3);
        run_plan();
        #1;
        vectors++;
        if (cycle_cnt !== 64'd1 || if_req_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL boot_exit got cycle=%0d ifv=%b expected cycle=1 ifv=1", cycle_cnt, if_req_valid);
        end
    endtask

    task automatic test_alu();
        do_reset(2);
        plan_insn(K_ALU, 1'b1, 0, 0, 1'b0, 0, 0, 1'b0);
        plan_insn(K_ALU, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
        plan_insn(K_ALU, 1'b1, 0, 0, 1'b0, 0, 0, 1'b0);
        run_plan();
        vectors++;
        if (pc_mask !== 64'h0000_0000_0000_1110 || pc_n != 3) begin
            miscompares++;
            $display("FAIL alu_pc_we_cycles got mask=%h n=%0d expected mask=1110 n=3", pc_mask, pc_n);
        end
        vectors++;
        if (instret_cnt !== 64'd3 || rf_n != 2) begin
            miscompares++;
            $display("FAIL alu_retire got instret=%0d rf=%0d expected instret=3 rf=2", instret_cnt, rf_n);
        end
    endtask

    task automatic test_load();
        do_reset(2);
        plan_insn(K_LD, 1'b1, 0, 0, 1'b0, 3, 1, 1'b0);
        run_plan();
        vectors++;
        if (lsv_n != 4 || rf_n != 1 || pc_n != 1 || instret_cnt !== 64'd1) begin
            miscompares++;
            $display("FAIL load_handshake got lsv=%0d rf=%0d pc=%0d instret=%0d expected 4 1 1 1",
                     lsv_n, rf_n, pc_n, instret_cnt);
        end
    endtask

    task automatic test_halt_priority();
        do_reset(2);
        plan_insn(K_BOTH, 1'b1, 0, 0, 1'b0, 0, 0, 1'b0);
        plan_idle(20);
        run_plan();
        vectors++;
        if (halted !== 1'b1 || halt_code !== 2'b01 || cycle_cnt !== 64'd4 || pc_n != 0) begin
            miscompares++;
            $display("FAIL illegal_over_ebreak got halted=%b code=%b cycle=%0d pc=%0d expected 1 01 4 0",
                     halted, halt_code, cycle_cnt, pc_n);
        end
        do_reset(2);
        plan_insn(K_EB, 1'b1, 1, 0, 1'b0, 0, 0, 1'b0);
        plan_idle(5);
        run_plan();
        vectors++;
        if (halt_code !== 2'b00 || cycle_cnt !== 64'd5) begin
            miscompares++;
            $display("FAIL ebreak got code=%b cycle=%0d expected 00 5", halt_code, cycle_cnt);
        end
    endtask

    task automatic test_timeout();
        do_reset(2);
        plan_insn(K_ALU, 1'b1, 9, 0, 1'b0, 0, 0, 1'b0);
        plan_idle(4);
        run_plan();
        vectors++;
        if (ifv_n != 4 || halt_code !== 2'b10 || cycle_cnt !== 64'd5) begin
            miscompares++;
            $display("FAIL if_req_timeout got ifv=%0d code=%b cycle=%0d expected 4 10 5", ifv_n, halt_code, cycle_cnt);
        end
        do_reset(2);
        plan_insn(K_LD, 1'b1, 0, 0, 1'b0, 1, 7, 1'b0);
        plan_idle(3);
        run_plan();
        vectors++;
        if (halt_code !== 2'b11 || pc_n != 0 || rf_n != 0) begin
            miscompares++;
            $display("FAIL mem_wait_timeout got code=%b pc=%0d rf=%0d expected 11 0 0", halt_code, pc_n, rf_n);
        end
    endtask

    task automatic test_lsu_err();
        do_reset(2);
        plan_insn(K_ST, 1'b1, 0, 1, 1'b0, 0, 2, 1'b1);
        plan_idle(4);
        run_plan();
        vectors++;
        if (halt_code !== 2'b11 || halted !== 1'b1 || pc_n != 0 || rf_n != 0) begin
            miscompares++;
            $display("FAIL lsu_err got halted=%b code=%b pc=%0d rf=%0d expected 1 11 0 0", halted, halt_code, pc_n, rf_n);
        end
        do_reset(2);
        plan_insn(K_ALU, 1'b1, 0, 2, 1'b1, 0, 0, 1'b0);
        plan_idle(2);
        run_plan();
        vectors++;
        if (halt_code !== 2'b10 || pc_n != 0) begin
            miscompares++;
            $display("FAIL fetch_err got code=%b pc=%0d expected 10 0", halt_code, pc_n);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(2);
        plan_insn(K_LD, 1'b1, 0, 0, 1'b0, 0, 3, 1'b0);
        repeat (3) void'(plan.pop_back());
        run_plan();
        force_stray = 1'b1;
        do_reset(2);
        plan_insn(K_ALU, 1'b1, 0, 0, 1'b0, 0, 0, 1'b0);
        run_plan();
        force_stray = 1'b0;
        vectors++;
        if (pc_n != 1 || rf_n != 1 || instret_cnt !== 64'd1 || cycle_cnt !== 64'd5) begin
            miscompares++;
            $display("FAIL reset_mid_mem got pc=%0d rf=%0d instret=%0d cycle=%0d expected 1 1 1 5",
                     pc_n, rf_n, instret_cnt, cycle_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int kind, r;
        do_reset(2);
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 19);
            kind = (r < 10) ? K_ALU : (r < 14) ? K_LD : (r < 18) ? K_ST : (r == 18) ? K_EB : K_INV;
            plan_insn(kind, 1'($urandom),
                      ($urandom_range(0, 11) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3),
                      ($urandom_range(0, 11) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3),
                      ($urandom_range(0, 24) == 0),
                      ($urandom_range(0, 11) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3),
                      ($urandom_range(0, 11) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3),
                      ($urandom_range(0, 24) == 0));
            if (plan_halted) plan_idle(3);
            run_plan();
            if (plan_halted) do_reset($urandom_range(1, 3));
        end
        run_plan();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_halt_priority();
        test_timeout();
        test_lsu_err();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ysyx_22040237_cpu_ctrl.md
Name: ysyx_22040237_cpu_ctrl

Overview:
Multi-cycle sequencer for the RV64 core datapath (pc register, IFU, IDU, EXU, register file). It replaces the implicit every-cycle commit of the single-cycle top with explicit per-instruction phases:
- fetch handshake;
- execute;
- optional load/store handshake;
- writeback.
It generates the pc and register-file write strobes, the instruction latch enable and the halt/trap status, and keeps the mcycle/minstret counters.

Parameters:
CNT_W, 64, width of cycle_cnt and instret_cnt.
TIMEOUT, 255, maximum cycles spent in any REQ/WAIT state before a bus-timeout halt; 0 disables the timeout.
TO_W, 8, width of the timeout counter; must hold TIMEOUT.

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
if_req_valid  output  1  instruction fetch request
if_req_ready  input  1  fetch request accepted
if_rsp_valid  input  1  fetched instruction valid on inst bus
if_rsp_err  input  1  fetch bus error, qualified by if_rsp_valid
inst_latch_en  output  1  capture the fetched instruction into the IFU register
is_load  input  1  IDU decode: load
is_store  input  1  IDU decode: store
rd_w_en  input  1  IDU decode: instruction writes rd
inst_ebreak  input  1  IDU decode: ebreak
invalid_inst  input  1  IDU decode: illegal instruction
lsu_req_valid  output  1  data memory request
lsu_req_ready  input  1  data request accepted
lsu_rsp_valid  input  1  data response (load data or store ack)
lsu_rsp_err  input  1  data bus error, qualified by lsu_rsp_valid
pc_we  output  1  pc register update (next pc or jump target)
rf_we  output  1  register file write strobe
halted  output  1  core stopped; sticky until rst
halt_code  output  2  00 ebreak, 01 illegal, 10 fetch error/timeout, 11 lsu error/timeout
cycle_cnt  output  CNT_W  cycles since reset while not halted
instret_cnt  output  CNT_W  retired instructions

Behaviour:
- States: BOOT, IF_REQ, IF_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, HALT.
- Reset (rst high at a clk edge, from any state, including mid-handshake):
  - state=BOOT;
  - all strobes 0, halted=0, halt_code=00, both counters 0, timeout counter 0.
  - Any in-flight bus response after reset is ignored; responses are only sampled in WAIT states.
- BOOT -> IF_REQ unconditionally, one cycle.
- IF_REQ:
  - if_req_valid=1, held until if_req_ready=1 in the same cycle, then -> IF_WAIT.
  - Response is not sampled in IF_REQ.
- IF_WAIT:
  - On if_rsp_valid & !if_rsp_err: inst_latch_en=1 combinationally in that cycle, -> EXEC.
  - On if_rsp_valid & if_rsp_err: -> HALT, code 10.
- EXEC: one cycle; decode inputs are valid only here. Priority order:
  1. invalid_inst -> HALT 01;
  2. inst_ebreak -> HALT 00;
  3. is_load|is_store -> MEM_REQ;
  4. otherwise -> WB.
- MEM_REQ / MEM_WAIT:
  - Same handshake as fetch, using the lsu_* ports.
  - lsu_rsp_valid & !err -> WB.
  - lsu_rsp_valid & err -> HALT 11; on this path pc_we and rf_we are never asserted.
- WB: one cycle.
  - pc_we=1 and rf_we=rd_w_en, both combinational from state. The IDU is stable because the instruction is latched.
  - instret_cnt increments on the next edge.
  - -> IF_REQ.
- Timeout:
  - The counter clears on every state change and increments each cycle spent in IF_REQ, IF_WAIT, MEM_REQ or MEM_WAIT.
  - When TIMEOUT!=0 and the count equals TIMEOUT-1 while still waiting: -> HALT, code 10 (IF states) or 11 (MEM states).
  - A handshake completing in that same cycle takes precedence over the timeout.
- HALT:
  - All strobes 0; halted=1 and halt_code are registered at HALT entry and stay stable.
  - cycle_cnt frozen; exits only on rst.
- cycle_cnt increments every cycle in which state != HALT and rst=0, including BOOT.
- Both counters wrap modulo 2^CNT_W with no saturation.
- Minimum latency per instruction, with ready and rsp asserted in the first possible cycle:
  - ALU/jump instruction: 4 cycles (IF_REQ, IF_WAIT, EXEC, WB);
  - load/store: 6 cycles.
- At most one outstanding request on each interface; if_req_valid and lsu_req_valid are never high together.

Test Plan:
- Reset then 3 ALU ops, ready/rsp immediate -> pc_we pulses at cycles 4, 8, 12 after BOOT exit; instret_cnt=3 after the third; rf_we mirrors rd_w_en.
- Load with lsu_req_ready delayed 3 cycles and rsp 2 cycles after accept -> lsu_req_valid held 4 cycles; single rf_we pulse in WB; pc_we exactly once.
- EXEC with inst_ebreak=1 and invalid_inst=1 -> halted=1, halt_code=01; no pc_we; cycle_cnt frozen for 20 further cycles.
- TIMEOUT=4, if_req_ready held 0 -> HALT with code 10 after 4 cycles in IF_REQ; if_req_valid drops in the HALT cycle.
- lsu_rsp_valid with lsu_rsp_err=1 -> halt_code=11; rf_we and pc_we never asserted for that instruction.
- rst asserted in MEM_WAIT, then stray lsu_rsp_valid during BOOT/IF_REQ -> ignored; counters 0; the next fetch proceeds normally.
